// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: opcodes, FSM states, instruction classes, pc_sel/trap codes and opcode decode
package multicycle_ctrl_pkg;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_OP        = 7'b0110011;
    localparam logic [6:0] OP_OP_32     = 7'b0111011;
    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_IMM  = 2'b01;
    localparam logic [1:0] PC_RS1  = 2'b10;
    localparam logic [1:0] PC_TRAP = 2'b11;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
    localparam logic [1:0] CAUSE_IFETCH  = 2'd1;
    localparam logic [1:0] CAUSE_DMEM    = 2'd2;
    localparam logic [1:0] CAUSE_ECALL   = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP} state_t;
    typedef enum logic [2:0] {C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_FENCE, C_SYSTEM} cls_t;

    typedef struct packed {
        logic legal;
        cls_t cls;
    } dec_t;

    function automatic dec_t decode(input logic [6:0] op);
        dec_t d;
        d.legal = 1'b1;
        d.cls   = C_ALU;
        case (op)
            OP_LOAD:     d.cls = C_LOAD;
            OP_STORE:    d.cls = C_STORE;
            OP_BRANCH:   d.cls = C_BRANCH;
            OP_JAL:      d.cls = C_JAL;
            OP_JALR:     d.cls = C_JALR;
            OP_MISC_MEM: d.cls = C_FENCE;
            OP_SYSTEM:   d.cls = C_SYSTEM;
            OP_OP_IMM, OP_OP_IMM_32, OP_OP, OP_OP_32, OP_LUI, OP_AUIPC: d.cls = C_ALU;
            default:     d.legal = 1'b0;
        endcase
        return d;
    endfunction
endpackage

// File: rtl/multicycle_ctrl_watchdog.sv
// mc_watchdog: bus wait counter, terminal count after TIMEOUT waiting cycles, tied low when TIMEOUT=0
module mc_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    if (TIMEOUT == 0) begin : g_off
        logic unused_wd;
        assign unused_wd = &{clk, rst_n, clr, en};
        assign tc = 1'b0;
    end else begin : g_on
        localparam int W = $clog2(TIMEOUT + 1);
        localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
        logic [W-1:0] cnt;
        // count cycles spent waiting; cnt==LAST marks the final permitted wait cycle
        always_ff @(posedge clk) begin
            if (!rst_n || clr) cnt <= '0;
            else if (en) cnt <= cnt + 1'b1;
        end
        assign tc = cnt == LAST;
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV64 multi-cycle sequencer IF/ID/EX/MEM/WB/TRAP; MULTICYCLE_CTRL_ZICSR_EN enables CSR ops and csr_we
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             br_taken,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_we,
    output logic             ex_en,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             rf_we,
`ifdef MULTICYCLE_CTRL_ZICSR_EN
    output logic             csr_we,
`endif
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic             busy,
    output logic             instret,
    output logic [CNT_W-1:0] instret_cnt
);
`ifdef MULTICYCLE_CTRL_ZICSR_EN
    localparam bit ZICSR = 1'b1;
`else
    localparam bit ZICSR = 1'b0;
`endif

    state_t     state;
    cls_t       cls;
    dec_t       dec;
    logic       wd_tc, waiting, is_mem, sys, illegal, ecall;
    logic       if_to, mem_to, go_trap, go_wb, wb_rf;
    logic [1:0] trap_code, wb_sel;

    assign waiting = state == S_IF || state == S_MEM;

    mc_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (!waiting),
        .en   (waiting),
        .tc   (wd_tc)
    );

    assign dec       = decode(opcode);
    assign sys       = opcode == OP_SYSTEM;
    assign illegal   = !dec.legal || (sys && funct3 != 3'd0 && !ZICSR);
    assign ecall     = sys && funct3 == 3'd0;
    assign if_to     = state == S_IF && !imem_ack && wd_tc;
    assign mem_to    = state == S_MEM && !dmem_ack && wd_tc;
    assign go_trap   = if_to || mem_to || (state == S_ID && (illegal || ecall));
    assign trap_code = if_to ? CAUSE_IFETCH : mem_to ? CAUSE_DMEM : ecall ? CAUSE_ECALL : CAUSE_ILLEGAL;
    assign is_mem    = cls == C_LOAD || cls == C_STORE;
    assign go_wb     = (state == S_EX && !is_mem) || (state == S_MEM && dmem_ack);
    assign wb_rf     = !(cls == C_BRANCH || cls == C_STORE || cls == C_FENCE);
    assign wb_sel    = cls == C_JAL ? PC_IMM : cls == C_JALR ? PC_RS1 :
                       (cls == C_BRANCH && br_taken) ? PC_IMM : PC_SEQ;

    // sequencer: state plus registered control outputs for the state being entered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cls         <= C_ALU;
            imem_req    <= 1'b0;
            ir_we       <= 1'b0;
            ex_en       <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            rf_we       <= 1'b0;
`ifdef MULTICYCLE_CTRL_ZICSR_EN
            csr_we      <= 1'b0;
`endif
            pc_we       <= 1'b0;
            pc_sel      <= PC_SEQ;
            trap        <= 1'b0;
            trap_cause  <= CAUSE_ILLEGAL;
            busy        <= 1'b0;
            instret     <= 1'b0;
            instret_cnt <= '0;
        end else begin
            ir_we   <= 1'b0;
            ex_en   <= 1'b0;
            rf_we   <= 1'b0;
`ifdef MULTICYCLE_CTRL_ZICSR_EN
            csr_we  <= 1'b0;
`endif
            pc_we   <= 1'b0;
            pc_sel  <= PC_SEQ;
            trap    <= 1'b0;
            instret <= 1'b0;
            case (state)
                S_IDLE: if (run) begin
                    state    <= S_IF;
                    imem_req <= 1'b1;
                    busy     <= 1'b1;
                end
                S_IF: if (imem_ack) begin
                    state    <= S_ID;
                    imem_req <= 1'b0;
                    ir_we    <= 1'b1;
                end
                S_ID: if (!go_trap) begin
                    state <= S_EX;
                    ex_en <= 1'b1;
                    cls   <= dec.cls;
                end
                S_EX: if (is_mem) begin
                    state    <= S_MEM;
                    dmem_req <= 1'b1;
                    dmem_we  <= cls == C_STORE;
                end
                S_MEM: if (dmem_ack) begin
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                end
                default: begin
                    state    <= run ? S_IF : S_IDLE;
                    imem_req <= run;
                    busy     <= run;
                end
            endcase
            if (go_wb) begin
                state       <= S_WB;
                pc_we       <= 1'b1;
                pc_sel      <= wb_sel;
                rf_we       <= wb_rf;
`ifdef MULTICYCLE_CTRL_ZICSR_EN
                csr_we      <= cls == C_SYSTEM;
`endif
                instret     <= 1'b1;
                instret_cnt <= instret_cnt + 1'b1;
            end
            if (go_trap) begin
                state      <= S_TRAP;
                trap       <= 1'b1;
                pc_we      <= 1'b1;
                pc_sel     <= PC_TRAP;
                trap_cause <= trap_code;
                imem_req   <= 1'b0;
                dmem_req   <= 1'b0;
                dmem_we    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized and directed checks of multicycle_ctrl against a per-instruction outcome model
module tb_multicycle_ctrl;
    localparam int TO = 4;
    localparam int CW = 4;
`ifdef MULTICYCLE_CTRL_ZICSR_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, run = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic br_taken = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
    logic imem_req, ir_we, ex_en, dmem_req, dmem_we, rf_we, pc_we, trap, busy, instret;
    logic [1:0] pc_sel, trap_cause;
    logic [CW-1:0] instret_cnt;
`ifdef MULTICYCLE_CTRL_ZICSR_EN
    logic csr_we;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct3(funct3), .br_taken(br_taken),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we), .ex_en(ex_en),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .rf_we(rf_we),
`ifdef MULTICYCLE_CTRL_ZICSR_EN
        .csr_we(csr_we),
`endif
        .pc_we(pc_we), .pc_sel(pc_sel), .trap(trap), .trap_cause(trap_cause), .busy(busy),
        .instret(instret), .instret_cnt(instret_cnt)
    );

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       bt;
        int         iw;
        int         dw;
    } stim_t;

    int errors = 0, checks = 0, exp_cnt = 0;
    int o_lat, o_ir, o_ircyc, o_ex, o_excyc, o_rf, o_pcwe, o_pcwecyc, o_trap, o_ret, o_dcyc;
    logic [1:0] o_sel, o_cause;
    logic o_dwe;

    // run one instruction with run dropped after issue; acks after iw / dw wait cycles
    task automatic exec(input stim_t s);
        int ic = 0, dc = 0, cyc = 0;
        bit started = 0, done = 0;
        {o_ir, o_ircyc, o_ex, o_excyc, o_rf, o_pcwe, o_pcwecyc, o_trap, o_ret} = '0;
        o_sel = 2'd0; o_cause = 2'd0; o_dwe = 1'b0;
        opcode = s.op; funct3 = s.f3; br_taken = s.bt; run = 1'b1;
        for (int n = 0; n < 80 && !done; n++) begin
            @(negedge clk);
            imem_ack = 1'b0; dmem_ack = 1'b0;
            if (!busy) begin
                done = started;
            end else begin
                started = 1; run = 1'b0; cyc++;
                if (imem_req) begin ic++; imem_ack = (ic == s.iw + 1); end
                if (dmem_req) begin dc++; dmem_ack = (dc == s.dw + 1); o_dwe |= dmem_we; end
                if (ir_we) begin o_ir++; o_ircyc = cyc; end
                if (ex_en) begin o_ex++; o_excyc = cyc; end
                if (rf_we) o_rf++;
                if (pc_we) begin o_pcwe++; o_pcwecyc = cyc; o_sel = pc_sel; end
                if (trap) begin o_trap++; o_cause = trap_cause; end
                if (instret) o_ret++;
            end
        end
        run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        o_lat = cyc; o_dcyc = dc;
        checks++;
        if (!done) begin errors++; $display("FAIL exec_bound op=%h: busy=%b started=%0d, want return to idle", s.op, busy, started); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({imem_req, ir_we, ex_en, dmem_req, dmem_we, rf_we, pc_we, pc_sel, trap, trap_cause, busy, instret} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0", {imem_req, ir_we, ex_en, dmem_req, dmem_we, rf_we, pc_we, pc_sel, trap, trap_cause, busy, instret});
        end
        checks++;
        if (instret_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", instret_cnt); end
        run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; rst_n = 1'b1; exp_cnt = 0;
        @(negedge clk);
    endtask

    task automatic test_instructions(input int n_rand);
        stim_t q[$];
        logic [6:0] ops[15] = '{7'h03, 7'h23, 7'h13, 7'h1B, 7'h33, 7'h3B, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h0F, 7'h73, 7'h7F, 7'h00};
        q.push_back(stim_t'{7'h13, 3'd0, 1'b0, 0, 0});
        q.push_back(stim_t'{7'h03, 3'd2, 1'b0, 0, 3});
        q.push_back(stim_t'{7'h23, 3'd2, 1'b0, 0, 0});
        q.push_back(stim_t'{7'h63, 3'd0, 1'b1, 0, 0});
        q.push_back(stim_t'{7'h63, 3'd0, 1'b0, 0, 0});
        q.push_back(stim_t'{7'h67, 3'd0, 1'b0, 1, 0});
        q.push_back(stim_t'{7'h6F, 3'd0, 1'b0, 0, 0});
        q.push_back(stim_t'{7'h7F, 3'd0, 1'b0, 0, 0});
        q.push_back(stim_t'{7'h73, 3'd0, 1'b0, 0, 0});
        q.push_back(stim_t'{7'h73, 3'd1, 1'b0, 0, 0});
        q.push_back(stim_t'{7'h13, 3'd0, 1'b0, 4, 0});
        q.push_back(stim_t'{7'h13, 3'd0, 1'b0, 3, 0});
        q.push_back(stim_t'{7'h03, 3'd3, 1'b0, 0, 4});
        q.push_back(stim_t'{7'h23, 3'd3, 1'b0, 2, 3});
        q.push_back(stim_t'{7'h0F, 3'd0, 1'b0, 0, 0});
        for (int i = 0; i < n_rand; i++)
            q.push_back(stim_t'{ops[$urandom_range(0, 14)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                                int'($urandom_range(0, 5)), int'($urandom_range(0, 5))});
        foreach (q[i]) begin
            stim_t s = q[i];
            bit legal, mem, e_trap, reach_ex;
            int e_lat, e_rf, e_ret, e_dcyc;
            logic [1:0] e_sel, e_cause;
            logic e_dwe;
            case (s.op)
                7'h03, 7'h23, 7'h13, 7'h1B, 7'h33, 7'h3B, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h0F: legal = 1;
                7'h73: legal = (s.f3 == 3'd0) || ZC;
                default: legal = 0;
            endcase
            mem = s.op == 7'h03 || s.op == 7'h23;
            e_trap = 1; e_cause = 2'd0; e_sel = 2'd3; e_rf = 0; e_ret = 0; e_dcyc = 0; reach_ex = 0;
            if (s.iw >= TO) begin
                e_cause = 2'd1; e_lat = TO + 1;
            end else if (!legal) begin
                e_lat = s.iw + 3;
            end else if (s.op == 7'h73 && s.f3 == 3'd0) begin
                e_cause = 2'd3; e_lat = s.iw + 3;
            end else if (mem && s.dw >= TO) begin
                reach_ex = 1; e_cause = 2'd2; e_dcyc = TO; e_lat = s.iw + 3 + TO + 1;
            end else begin
                reach_ex = 1; e_trap = 0; e_ret = 1;
                e_dcyc = mem ? s.dw + 1 : 0;
                e_lat = s.iw + 4 + e_dcyc;
                e_sel = s.op == 7'h6F ? 2'd1 : s.op == 7'h67 ? 2'd2 : (s.op == 7'h63 && s.bt) ? 2'd1 : 2'd0;
                e_rf = (s.op == 7'h63 || s.op == 7'h23 || s.op == 7'h0F) ? 0 : 1;
            end
            e_dwe = (s.op == 7'h23) && reach_ex;
            exec(s);
            exp_cnt = (exp_cnt + e_ret) % (1 << CW);
            checks++; if (o_lat !== e_lat) begin errors++; $display("FAIL latency op=%h iw=%0d dw=%0d: got %0d want %0d", s.op, s.iw, s.dw, o_lat, e_lat); end
            checks++; if (o_ir !== (s.iw < TO ? 1 : 0)) begin errors++; $display("FAIL ir_we_count op=%h: got %0d want %0d", s.op, o_ir, s.iw < TO); end
            if (s.iw < TO) begin
                checks++; if (o_ircyc !== s.iw + 2) begin errors++; $display("FAIL ir_we_cycle op=%h: got %0d want %0d", s.op, o_ircyc, s.iw + 2); end
            end
            checks++; if (o_ex !== int'(reach_ex)) begin errors++; $display("FAIL ex_en_count op=%h: got %0d want %0d", s.op, o_ex, reach_ex); end
            if (reach_ex) begin
                checks++; if (o_excyc !== s.iw + 3) begin errors++; $display("FAIL ex_en_cycle op=%h: got %0d want %0d", s.op, o_excyc, s.iw + 3); end
            end
            checks++; if (o_trap !== int'(e_trap)) begin errors++; $display("FAIL trap_count op=%h: got %0d want %0d", s.op, o_trap, e_trap); end
            if (e_trap) begin
                checks++; if (o_cause !== e_cause) begin errors++; $display("FAIL trap_cause op=%h f3=%0d: got %0d want %0d", s.op, s.f3, o_cause, e_cause); end
            end
            checks++; if (o_pcwe !== 1 || o_pcwecyc !== e_lat) begin errors++; $display("FAIL pc_we op=%h: got count %0d cycle %0d want 1 at %0d", s.op, o_pcwe, o_pcwecyc, e_lat); end
            checks++; if (o_sel !== e_sel) begin errors++; $display("FAIL pc_sel op=%h bt=%b: got %0d want %0d", s.op, s.bt, o_sel, e_sel); end
            checks++; if (o_rf !== e_rf) begin errors++; $display("FAIL rf_we op=%h: got %0d want %0d", s.op, o_rf, e_rf); end
            checks++; if (o_ret !== e_ret) begin errors++; $display("FAIL instret op=%h: got %0d want %0d", s.op, o_ret, e_ret); end
            checks++; if (o_dcyc !== e_dcyc) begin errors++; $display("FAIL dmem_req_cycles op=%h dw=%0d: got %0d want %0d", s.op, s.dw, o_dcyc, e_dcyc); end
            checks++; if (o_dwe !== e_dwe) begin errors++; $display("FAIL dmem_we op=%h: got %b want %b", s.op, o_dwe, e_dwe); end
            checks++; if (instret_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL instret_cnt op=%h: got %0d want %0d", s.op, instret_cnt, exp_cnt); end
        end
    endtask

    task automatic test_reset_mid_mem;
        bit hit = 0;
        opcode = 7'h03; funct3 = 3'd2; run = 1'b1;
        for (int n = 0; n < 30 && !hit; n++) begin
            @(negedge clk);
            if (busy) run = 1'b0;
            imem_ack = imem_req; dmem_ack = 1'b0;
            if (dmem_req) begin hit = 1; rst_n = 1'b0; end
        end
        imem_ack = 1'b0;
        checks++;
        if (!hit) begin errors++; $display("FAIL mid_mem_reach: dmem_req never seen, want 1"); end
        @(negedge clk);
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL mid_mem_dmem_req: got %b want 0", dmem_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_mem_busy: got %b want 0", busy); end
        checks++; if (instret_cnt !== '0) begin errors++; $display("FAIL mid_mem_cnt: got %0d want 0", instret_cnt); end
        rst_n = 1'b1; exp_cnt = 0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int nret = 0, last = 0, cyc = 0;
        bit prev_ret = 0, done = 0;
        opcode = 7'h33; funct3 = 3'd0; br_taken = 1'b0; run = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            cyc++;
            imem_ack = imem_req;
            if (prev_ret) begin
                checks++;
                if (instret_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL b2b_cnt ret=%0d: got %0d want %0d", nret, instret_cnt, exp_cnt); end
            end
            prev_ret = instret;
            if (instret) begin
                nret++;
                exp_cnt = (exp_cnt + 1) % (1 << CW);
                if (nret > 1) begin
                    checks++;
                    if (cyc - last !== 4) begin errors++; $display("FAIL b2b_spacing ret=%0d: got %0d want 4", nret, cyc - last); end
                end
                last = cyc;
                if (nret == (1 << CW)) run = 1'b0;
            end
            done = nret == (1 << CW) && !busy && !prev_ret;
        end
        imem_ack = 1'b0; run = 1'b0;
        checks++;
        if (nret !== (1 << CW) || !done) begin errors++; $display("FAIL b2b_retired: got %0d want %0d", nret, 1 << CW); end
    endtask

    initial begin
        test_reset;
        test_instructions(40);
        test_reset_mid_mem;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
